// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared types and widths for the data-memory responder
// Rev 1.0
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Index width for a DEPTH-entry array; never less than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array : DEPTH x 16 storage, byte-strobed synchronous write and
//              registered synchronous read. No reset on storage or read data.
// Rev 1.0
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : latency-programmable data-memory slave for the MEM stage,
//                  stalls the pipeline until each single access completes.
//                  Optional byte strobes with DMEM_BYTE_EN.
// Rev 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [1:0]        dm_be,
`endif
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              dm_ack,
  output logic              dm_err
);

  localparam int                AW      = addr_bits(DEPTH);
  localparam logic [CNT_W-1:0]  c_LAT   = CNT_W'(LATENCY);
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  op_e                 op_q, op_d;
  // Forces dm_rdata to zero after reset or an out-of-range read.
  logic                rzero_q, rzero_d;

  logic                w_req;
  logic                w_oor;
  logic                w_arr_we;
  logic                w_arr_re;
  logic [DATA_W-1:0]   w_arr_rdata;
  logic [1:0]          w_be_in;

`ifdef DMEM_BYTE_EN
  assign w_be_in = dm_be;
`else
  assign w_be_in = 2'b11;
`endif

  assign w_req = dm_re | dm_we;
  assign w_oor = ({1'b0, addr_q} >= c_DEPTH);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    op_d     = op_q;
    rzero_d  = rzero_q;
    w_arr_we = 1'b0;
    w_arr_re = 1'b0;
    dm_stall = 1'b0;
    case (state_q)
      IDLE: begin
        dm_stall = w_req;
        if (w_req) begin
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          be_d    = w_be_in;
          op_d    = dm_we ? OP_WR : OP_RD;
          cnt_d   = c_LAT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dm_stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (op_q == OP_WR) begin
            w_arr_we = ~w_oor & ~rst;
          end else begin
            w_arr_re = ~w_oor & ~rst;
            rzero_d  = w_oor;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      op_q    <= OP_RD;
      rzero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      op_q    <= op_d;
      rzero_q <= rzero_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (w_arr_we),
    .be_i    (be_q),
    .re_i    (w_arr_re),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (w_arr_rdata)
  );

  assign dm_rdata = rzero_q ? '0 : w_arr_rdata;
  assign dm_ack   = (state_q == DONE);
  assign dm_err   = (state_q == DONE) & w_oor;

endmodule
`default_nettype wire
